// File: rtl/eq_spi_regbank_pkg.sv
// rtl/eq_spi_regbank_pkg.sv - shared constants and types for the SPI EQ coefficient bank
package eq_spi_pkg;

    localparam int HDR_W         = 8;
    localparam int WR_BIT        = 7;
    localparam int ADDR_W        = 7;
    localparam int DEF_NUM_BANDS = 8;
    localparam int DEF_DATA_W    = 24;

    typedef struct packed {
        logic              wr;
        logic [ADDR_W-1:0] addr;
    } hdr_t;

    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr, input int num_bands);
        return int'(addr) < num_bands;
    endfunction

endpackage

// File: rtl/eq_spi_regbank_if.sv
// rtl/eq_spi_regbank_if.sv - SPI mode-0 pins bundled as an interface
interface eq_spi_regbank_if;
    logic sck;
    logic ce;
    logic sdi;
    logic sdo;

    modport master (output sck, output ce, output sdi, input sdo);
    modport slave  (input sck, input ce, input sdi, output sdo);
endinterface

// File: rtl/eq_spi_regbank_pulse_sync.sv
// rtl/eq_spi_regbank_pulse_sync.sv - toggle-to-pulse crossing: two sync flops plus edge detect
module pulse_sync (
    input  logic clk,
    input  logic realReset,
    input  logic toggle_in,
    output logic pulse_out
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    always_ff @(posedge clk or posedge realReset) begin
        if (realReset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= toggle_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign pulse_out = sync2_q ^ prev_q;

endmodule

// File: rtl/eq_spi_regbank.sv
// rtl/eq_spi_regbank.sv - SPI-written EQ coefficient bank with sck-side mirror for readback
module eq_spi_regbank
    import eq_spi_pkg::*;
#(
    parameter int NUM_BANDS = DEF_NUM_BANDS,
    parameter int DATA_W    = DEF_DATA_W
) (
    input  logic                        clk,
    input  logic                        realReset,
    eq_spi_regbank_if.slave             spi,
    output logic                        done,
    output logic [NUM_BANDS*DATA_W-1:0] coef,
    output logic                        coef_update,
    output logic [ADDR_W-1:0]           update_band
);

    localparam int FRAME_W = HDR_W + DATA_W;
    localparam int CNT_W   = $clog2(FRAME_W + 1);

    logic                 frame_rst;
    logic [CNT_W-1:0]     cnt_q;
    logic [FRAME_W-2:0]   shift_q;
    logic [FRAME_W-1:0]   frame_word;
    hdr_t                 frame_hdr;
    logic [DATA_W-1:0]    frame_data;
    logic                 frame_end;
    logic                 wr_ok;

    logic [ADDR_W-1:0]    hold_addr_q;
    logic [DATA_W-1:0]    hold_data_q;
    logic                 req_tog_q;
    logic [DATA_W-1:0]    mirror_q [NUM_BANDS];

    logic [ADDR_W-1:0]    rd_addr;
    logic [DATA_W-1:0]    rd_word;
    logic [DATA_W-1:0]    rd_q;

    logic                 upd_pulse;
    logic [DATA_W-1:0]    bank_q [NUM_BANDS];
    logic                 coef_update_q;
    logic [ADDR_W-1:0]    update_band_q;

    // Dropping ce discards any partial frame before the next edge can use it.
    assign frame_rst = realReset | ~spi.ce;

    always_ff @(posedge spi.sck or posedge frame_rst) begin
        if (frame_rst) begin
            cnt_q   <= '0;
            shift_q <= '0;
        end else if (cnt_q != CNT_W'(FRAME_W)) begin
            cnt_q   <= cnt_q + 1'b1;
            shift_q <= {shift_q[FRAME_W-3:0], spi.sdi};
        end
    end

    assign frame_word = {shift_q, spi.sdi};
    assign frame_hdr  = frame_word[FRAME_W-1 -: HDR_W];
    assign frame_data = frame_word[DATA_W-1:0];
    assign frame_end  = (cnt_q == CNT_W'(FRAME_W - 1));
    assign wr_ok      = frame_end && frame_hdr.wr && addr_in_range(frame_hdr.addr, NUM_BANDS);

    // Holding register and toggle survive ce so the clk side can sample them after the frame.
    always_ff @(posedge spi.sck or posedge realReset) begin
        if (realReset) begin
            hold_addr_q <= '0;
            hold_data_q <= '0;
            req_tog_q   <= 1'b0;
            for (int k = 0; k < NUM_BANDS; k++) begin
                mirror_q[k] <= '0;
            end
        end else if (wr_ok) begin
            hold_addr_q <= frame_hdr.addr;
            hold_data_q <= frame_data;
            req_tog_q   <= ~req_tog_q;
            for (int k = 0; k < NUM_BANDS; k++) begin
                if (frame_hdr.addr == ADDR_W'(k)) begin
                    mirror_q[k] <= frame_data;
                end
            end
        end
    end

    assign rd_addr = shift_q[ADDR_W-1:0];

    always_comb begin
        rd_word = '0;
        for (int k = 0; k < NUM_BANDS; k++) begin
            if (rd_addr == ADDR_W'(k)) begin
                rd_word = mirror_q[k];
            end
        end
    end

    // Loaded on the falling edge after the header; zeros fill in behind the last data bit.
    always_ff @(negedge spi.sck or posedge frame_rst) begin
        if (frame_rst) begin
            rd_q <= '0;
        end else if (cnt_q == CNT_W'(HDR_W)) begin
            rd_q <= rd_word;
        end else if (cnt_q > CNT_W'(HDR_W)) begin
            rd_q <= {rd_q[DATA_W-2:0], 1'b0};
        end
    end

    assign spi.sdo = rd_q[DATA_W-1];

    pulse_sync u_pulse_sync (
        .clk       (clk),
        .realReset (realReset),
        .toggle_in (req_tog_q),
        .pulse_out (upd_pulse)
    );

    always_ff @(posedge clk or posedge realReset) begin
        if (realReset) begin
            coef_update_q <= 1'b0;
            update_band_q <= '0;
            for (int k = 0; k < NUM_BANDS; k++) begin
                bank_q[k] <= '0;
            end
        end else begin
            coef_update_q <= upd_pulse;
            if (upd_pulse) begin
                update_band_q <= hold_addr_q;
                for (int k = 0; k < NUM_BANDS; k++) begin
                    if (hold_addr_q == ADDR_W'(k)) begin
                        bank_q[k] <= hold_data_q;
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_BANDS; g++) begin : g_coef
        assign coef[g*DATA_W +: DATA_W] = bank_q[g];
    end

    assign coef_update = coef_update_q;
    assign update_band = update_band_q;
    assign done        = ~spi.ce;

endmodule

// File: tb/tb_eq_spi_regbank.sv
// tb/tb_eq_spi_regbank.sv - scoreboard bench for eq_spi_regbank
module tb_eq_spi_regbank;

    localparam int NB = 8;
    localparam int DW = 24;

    logic            clk;
    logic            realReset;
    logic            done;
    logic [NB*DW-1:0] coef;
    logic            coef_update;
    logic [6:0]      update_band;

    eq_spi_regbank_if spi_if ();

    eq_spi_regbank #(.NUM_BANDS(NB), .DATA_W(DW)) dut (
        .clk         (clk),
        .realReset   (realReset),
        .spi         (spi_if),
        .done        (done),
        .coef        (coef),
        .coef_update (coef_update),
        .update_band (update_band)
    );

    initial clk = 1'b0;
    always #42 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_pulse  = 0;
    int          n_expect = 0;
    int          q_band [$];
    logic [DW-1:0] q_data [$];
    logic [DW-1:0] model [NB];
    time         t_end;

    task automatic check(input string tag, input logic [NB*DW-1:0] obs, input logic [NB*DW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NB*DW-1:0] model_flat();
        logic [NB*DW-1:0] f;
        f = '0;
        for (int k = 0; k < NB; k++) f[k*DW +: DW] = model[k];
        return f;
    endfunction

    always @(negedge clk) begin
        if (coef_update === 1'b1) begin
            int          eb;
            logic [DW-1:0] ed;
            n_pulse++;
            if (q_band.size() == 0) begin
                check("unexpected_update", 1'b1, 1'b0);
            end else begin
                eb = q_band.pop_front();
                ed = q_data.pop_front();
                check("update_band", update_band, eb);
                check("coef_new", coef[eb*DW +: DW], ed);
                check("latency", (($time - t_end) <= 4 * 84), 1'b1);
            end
        end
    end

    task automatic spi_frame(input logic [7:0] hdr, input logic [DW-1:0] data,
                             input int nbits, input int rst_at);
        logic [31:0]   word;
        logic [DW-1:0] rd;
        logic [DW-1:0] exp_rd;
        logic          hdr_sdo;
        logic          tail_sdo;
        logic          aborted;
        word     = {hdr, data};
        rd       = '0;
        hdr_sdo  = 1'b0;
        tail_sdo = 1'b0;
        aborted  = 1'b0;
        exp_rd   = (hdr[6:0] < NB) ? model[hdr[2:0]] : '0;
        if (nbits >= 32 && rst_at == 0 && hdr[7] && hdr[6:0] < NB) begin
            model[hdr[2:0]] = data;
            q_band.push_back(int'(hdr[6:0]));
            q_data.push_back(data);
            n_expect++;
        end
        spi_if.ce = 1'b1;
        #500;
        for (int i = 1; i <= nbits; i++) begin
            spi_if.sdi = (i <= 32) ? word[32-i] : 1'b0;
            #250;
            if (i <= 8)       hdr_sdo  = hdr_sdo | spi_if.sdo;
            else if (i <= 32) rd       = {rd[DW-2:0], spi_if.sdo};
            else              tail_sdo = tail_sdo | spi_if.sdo;
            #250;
            spi_if.sck = 1'b1;
            if (i == 32) t_end = $time;
            if (i == rst_at) begin
                #200;
                realReset = 1'b1;
                #100;
                check("rst_coef", coef, '0);
                check("rst_update", coef_update, 1'b0);
                check("rst_band", update_band, 7'd0);
                check("rst_sdo", spi_if.sdo, 1'b0);
                realReset = 1'b0;
                for (int k = 0; k < NB; k++) model[k] = '0;
                aborted = 1'b1;
                #200;
                spi_if.sck = 1'b0;
                break;
            end
            #500;
            spi_if.sck = 1'b0;
        end
        #500;
        spi_if.ce  = 1'b0;
        spi_if.sdi = 1'b0;
        #1000;
        check("sdo_idle", spi_if.sdo, 1'b0);
        if (!aborted && nbits >= 32) begin
            check("hdr_sdo", hdr_sdo, 1'b0);
            check("readback", rd, exp_rd);
        end
        if (nbits > 32) check("tail_sdo", tail_sdo, 1'b0);
        check("pending", q_band.size(), 0);
        check("coef_bank", coef, model_flat());
    endtask

    initial begin
        for (int k = 0; k < NB; k++) model[k] = '0;
        t_end      = 0;
        realReset  = 1'b1;
        spi_if.sck = 1'b0;
        spi_if.ce  = 1'b0;
        spi_if.sdi = 1'b0;
        #500;
        check("reset_coef", coef, '0);
        check("reset_update", coef_update, 1'b0);
        check("reset_sdo", spi_if.sdo, 1'b0);
        check("done_ce0", done, 1'b1);
        spi_if.ce = 1'b1;
        #10;
        check("done_ce1", done, 1'b0);
        spi_if.ce = 1'b0;
        #10;
        realReset = 1'b0;
        #1000;
        check("post_reset_coef", coef, '0);

        spi_frame(8'h83, 24'h123456, 32, 0);
        spi_frame(8'h03, 24'h000000, 32, 0);
        spi_frame(8'h85, 24'hABCDEF, 20, 0);
        spi_frame(8'h85, 24'h00FF00, 32, 0);
        spi_frame(8'h8A, 24'h777777, 32, 0);
        spi_frame(8'h0A, 24'h000000, 32, 0);
        spi_frame(8'h81, 24'h00BEEF, 32, 15);
        spi_frame(8'h81, 24'h000001, 32, 0);
        spi_frame(8'h80, 24'hA5A5A5, 32, 0);
        spi_frame(8'h87, 24'hFFFFFF, 32, 0);
        spi_frame(8'h80, 24'h5A5A5A, 32, 0);
        spi_frame(8'h82, 24'h800001, 36, 0);
        spi_frame(8'h07, 24'h000000, 32, 0);
        spi_frame(8'h02, 24'h000000, 32, 0);

        #2000;
        check("pulse_count", n_pulse, n_expect);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/eq_spi_regbank.md
EQ_SPI_REGBANK -- requirements
Module: eq_spi_regbank

Interface
REQ-001 Parameter NUM_BANDS, default 8, number of EQ coefficient registers (1..128).
REQ-002 Parameter DATA_W, default 24, coefficient width in bits (8..32).
REQ-003 Port clk  input  1  system clock; coefficient bank and update strobe live here.
REQ-004 Port realReset  input  1  reset, asynchronous, active-high, applies to both clock domains.
REQ-005 Port sck  input  1  SPI clock, mode 0: sdi sampled on rising edge, sdo driven on falling edge.
REQ-006 Port ce  input  1  chip enable, active-high; frame spans one ce-high interval.
REQ-007 Port sdi  input  1  serial data in, MSB first.
REQ-008 Port sdo  output  1  serial readback data, MSB first.
REQ-009 Port coef  output  NUM_BANDS*DATA_W  flattened bank; band k at bits [k*DATA_W +: DATA_W].
REQ-010 Port coef_update  output  1  one-clk pulse when a bank register is written.
REQ-011 Port update_band  output  7  index of band written; valid while coef_update is high.
REQ-012 Port done  output  1  equals ~ce.

Function
REQ-013 Frame = 8-bit header then DATA_W data bits; FRAME_W = 8 + DATA_W.
REQ-014 Header bit 7 = write flag (1 write, 0 read); header bits 6:0 = band address.
REQ-015 sck domain: shift register and bit counter advance on each sck rising edge while ce high.
REQ-016 Bit counter saturates at FRAME_W; bits after FRAME_W within the same ce interval are ignored.
REQ-017 ce low asynchronously clears bit counter and shift register; a frame with fewer than FRAME_W bits has no effect.
REQ-018 On the FRAME_W-th rising edge of a write frame with address < NUM_BANDS: capture {address, data} into a holding register, update the sck-domain mirror entry, toggle the request flag.
REQ-019 Write with address >= NUM_BANDS: no capture, no toggle, no mirror change.
REQ-020 Read frames never toggle the request flag and never change bank or mirror.
REQ-021 sdo = 0 during header bits; on the falling edge after the 8th rising edge, sdo presents MSB of mirror[address]; each later falling edge shifts the next bit.
REQ-022 Readback of address >= NUM_BANDS returns all zeros; sdo = 0 after the last data bit and while ce low.
REQ-023 Readback is returned for read and write frames alike; a write frame returns the value before the write.
REQ-024 clk domain: request toggle passes through 2-flop synchronizer plus one edge-detect flop; on detected edge, bank[address] <= data and coef_update pulses for exactly one clk.
REQ-025 coef reflects the new value in the same cycle coef_update is high; latency <= 4 clk edges after the toggle flips.
REQ-026 Holding register is stable from toggle until the next valid frame end; supported operation requires f_clk >= f_sck / 4, so at most one request is in flight.
REQ-027 Back-to-back valid write frames each produce exactly one coef_update, in order.

Reset
REQ-028 realReset high: bank, mirror, holding register, toggle flags, synchronizer, counter cleared to 0; coef = 0, coef_update = 0, update_band = 0, sdo = 0.
REQ-029 realReset asserted mid-frame aborts the frame; the first complete frame after release is processed normally.
REQ-030 No coef_update pulse arises from reset assertion or release.

Structure
REQ-031 Package eq_spi_pkg holds HDR_W = 8, WR_BIT = 7, ADDR_W = 7, default NUM_BANDS and DATA_W.
REQ-032 Toggle synchronizer plus edge detect is sub-module pulse_sync (clk, realReset, toggle_in, pulse_out).
REQ-033 Target size 150-300 lines RTL excluding package.

Verification (NUM_BANDS=8, DATA_W=24, clk 12 MHz, sck 1 MHz)
REQ-034 Pulse realReset -> coef = 0, coef_update = 0, sdo = 0, done follows ~ce.
REQ-035 Write frame 0x83, 0x123456 -> bank 3 = 0x123456 within 4 clk of the 32nd sck edge, one coef_update with update_band = 3, other bands 0.
REQ-036 Read frame 0x03 after the REQ-035 write -> sdo bits 9..32 = 0x123456 MSB first, no coef_update, bank unchanged.
REQ-037 Write 0x85, 0xABCDEF with ce dropped after 20 bits -> no coef_update, bank 5 = 0; next full frame 0x85, 0x00FF00 -> bank 5 = 0x00FF00.
REQ-038 Write 0x8A, 0x777777 -> no coef_update; read 0x0A -> sdo all zeros.
REQ-039 realReset during bit 15 of write 0x81 -> all outputs 0; subsequent write 0x81, 0x000001 -> bank 1 = 0x000001 with one coef_update.
